// File: rtl/alu_driver_pkg.sv
// rtl/alu_driver_pkg.sv - FSM state type, opcode width, default width and address-width helper for alu_driver
package alu_driver_pkg;

    localparam int OPC_W     = 3;
    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    // log2(NREG), never narrower than one bit so a two-entry file still has an address
    function automatic int addr_w(input int nreg);
        return (nreg > 2) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/alu_driver_regfile.sv
// rtl/alu_driver_regfile.sv - NREG x WIDTH operand register file, load + writeback ports, writeback wins
module alu_driver_regfile
    import alu_driver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREG  = 4,
    parameter int AW    = addr_w(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld_en_i,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             wb_en_i,
    input  logic [AW-1:0]    wb_addr_i,
    input  logic [WIDTH-1:0] wb_data_i,
    input  logic [AW-1:0]    rda_addr_i,
    output logic [WIDTH-1:0] rda_data_o,
    input  logic [AW-1:0]    rdb_addr_i,
    output logic [WIDTH-1:0] rdb_data_o,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] regs_q [NREG];

    // The writeback assignment comes last so it overrides a same-address load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_en_i) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_en_i) begin
                regs_q[wb_addr_i] <= wb_data_i;
            end
        end
    end

    assign rda_data_o = regs_q[rda_addr_i];
    assign rdb_data_o = regs_q[rdb_addr_i];
    assign rd_data_o  = regs_q[rd_addr_i];

endmodule

// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - ALU command driver: latch operands, hold ALU inputs SETTLE cycles, capture and write back
// Optional ALU_FLAG_CHECK_EN adds a sticky flag_err output comparing ALU flags against the result.
module alu_driver
    import alu_driver_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NREG   = 4,
    parameter int SETTLE = 1,
    parameter int AW     = addr_w(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [OPC_W-1:0] cmd_opc,
    input  logic             cmd_inc,
    input  logic [AW-1:0]    cmd_srca,
    input  logic [AW-1:0]    cmd_srcb,
    input  logic [AW-1:0]    cmd_dst,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    output logic [WIDTH-1:0] alu_inA,
    output logic [WIDTH-1:0] alu_inB,
    output logic             alu_inc,
    output logic [OPC_W-1:0] alu_opc,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             flag_zer,
    output logic             flag_neg,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
`ifdef ALU_FLAG_CHECK_EN
    ,
    output logic             flag_err
`endif
);

    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opb_q, res_q;
    logic [OPC_W-1:0] opc_q;
    logic             inc_q;
    logic [AW-1:0]    dst_q;
    logic             done_q, zer_q, neg_q;
    logic             accept, capture;
    logic [WIDTH-1:0] rda_data, rdb_data;

    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign capture   = (state_q == CAPTURE);

    alu_driver_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .AW    (AW)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .wb_en_i    (capture),
        .wb_addr_i  (dst_q),
        .wb_data_i  (alu_w),
        .rda_addr_i (cmd_srca),
        .rda_data_o (rda_data),
        .rdb_addr_i (cmd_srcb),
        .rdb_data_o (rdb_data),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
            end
            ISSUE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands are sampled from the pre-edge file contents, so a same-edge load is not seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
            opc_q <= '0;
            inc_q <= 1'b0;
            dst_q <= '0;
        end else if (accept) begin
            opa_q <= rda_data;
            opb_q <= rdb_data;
            opc_q <= cmd_opc;
            inc_q <= cmd_inc;
            dst_q <= cmd_dst;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            res_q  <= '0;
            zer_q  <= 1'b0;
            neg_q  <= 1'b0;
        end else begin
            done_q <= capture;
            if (capture) begin
                res_q <= alu_w;
                zer_q <= alu_zer;
                neg_q <= alu_neg;
            end
        end
    end

    assign alu_inA  = opa_q;
    assign alu_inB  = opb_q;
    assign alu_inc  = inc_q;
    assign alu_opc  = opc_q;
    assign done     = done_q;
    assign res      = res_q;
    assign flag_zer = zer_q;
    assign flag_neg = neg_q;

`ifdef ALU_FLAG_CHECK_EN
    logic err_q;
    logic calc_zer, calc_neg;

    assign calc_zer = (alu_w == '0);
    assign calc_neg = alu_w[WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (capture && ((calc_zer != alu_zer) || (calc_neg != alu_neg))) begin
            err_q <= 1'b1;
        end
    end

    assign flag_err = err_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with an adder ALU stub and a register-file model
module tb_alu_driver;

    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        force_zer;

    logic        cmd_valid, cmd_ready, cmd_inc;
    logic [2:0]  cmd_opc;
    logic [1:0]  cmd_srca, cmd_srcb, cmd_dst;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_inA, alu_inB, alu_w;
    logic        alu_inc, alu_zer, alu_neg;
    logic [2:0]  alu_opc;
    logic        done, flag_zer, flag_neg;
    logic [15:0] res;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;

    logic        s_cmd_valid, s_cmd_ready, s_cmd_inc;
    logic [2:0]  s_cmd_opc;
    logic [1:0]  s_cmd_srca, s_cmd_srcb, s_cmd_dst;
    logic        s_ld_en;
    logic [1:0]  s_ld_addr;
    logic [15:0] s_ld_data;
    logic [15:0] s_alu_inA, s_alu_inB, s_alu_w;
    logic        s_alu_inc, s_alu_zer, s_alu_neg;
    logic [2:0]  s_alu_opc;
    logic        s_done, s_flag_zer, s_flag_neg;
    logic [15:0] s_res;
    logic [1:0]  s_rd_addr;
    logic [15:0] s_rd_data;
`ifdef ALU_FLAG_CHECK_EN
    logic        flag_err, s_flag_err;
`endif

    assign alu_w   = alu_inA + alu_inB + {15'd0, alu_inc};
    assign alu_zer = force_zer | (alu_w == 16'd0);
    assign alu_neg = alu_w[15];

    assign s_alu_w   = s_alu_inA + s_alu_inB + {15'd0, s_alu_inc};
    assign s_alu_zer = (s_alu_w == 16'd0);
    assign s_alu_neg = s_alu_w[15];

    alu_driver #(.WIDTH(16), .NREG(4), .SETTLE(S1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opc(cmd_opc), .cmd_inc(cmd_inc),
        .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb), .cmd_dst(cmd_dst),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inc(alu_inc), .alu_opc(alu_opc),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .done(done), .res(res), .flag_zer(flag_zer), .flag_neg(flag_neg),
        .rd_addr(rd_addr), .rd_data(rd_data)
`ifdef ALU_FLAG_CHECK_EN
        , .flag_err(flag_err)
`endif
    );

    alu_driver #(.WIDTH(16), .NREG(4), .SETTLE(S3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_opc(s_cmd_opc), .cmd_inc(s_cmd_inc),
        .cmd_srca(s_cmd_srca), .cmd_srcb(s_cmd_srcb), .cmd_dst(s_cmd_dst),
        .ld_en(s_ld_en), .ld_addr(s_ld_addr), .ld_data(s_ld_data),
        .alu_inA(s_alu_inA), .alu_inB(s_alu_inB), .alu_inc(s_alu_inc), .alu_opc(s_alu_opc),
        .alu_w(s_alu_w), .alu_zer(s_alu_zer), .alu_neg(s_alu_neg),
        .done(s_done), .res(s_res), .flag_zer(s_flag_zer), .flag_neg(s_flag_neg),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data)
`ifdef ALU_FLAG_CHECK_EN
        , .flag_err(s_flag_err)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] mreg [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mreg[i] = 16'd0;
    endtask

    task automatic load(input logic [1:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
        mreg[a] = d;
    endtask

    // mode 0: no side load; 1: load during ISSUE; 2: load on the CAPTURE edge
    task automatic op(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] dst,
                      input logic inc, input logic [2:0] opc,
                      input int mode, input logic [1:0] la, input logic [15:0] ld);
        logic [15:0] a, b, w;
        int lat;
        a = mreg[sa];
        b = mreg[sb];
        w = a + b + {15'd0, inc};
        chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_srca = sa; cmd_srcb = sb; cmd_dst = dst; cmd_inc = inc; cmd_opc = opc;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
        chk("alu_inA", {16'd0, alu_inA}, {16'd0, a});
        chk("alu_inB", {16'd0, alu_inB}, {16'd0, b});
        chk("alu_inc", {31'd0, alu_inc}, {31'd0, inc});
        chk("alu_opc", {29'd0, alu_opc}, {29'd0, opc});
        lat = 1;
        while (!done && lat < 20) begin
            ld_en = ((mode == 1) && (lat == 1)) || ((mode == 2) && (lat == 2));
            ld_addr = la; ld_data = ld;
            @(negedge clk);
            lat++;
        end
        ld_en = 1'b0;
        if (mode != 0) mreg[la] = ld;
        mreg[dst] = w;
        chk("latency", lat, S1 + 2);
        chk("alu_inA_hold", {16'd0, alu_inA}, {16'd0, a});
        chk("res", {16'd0, res}, {16'd0, w});
        chk("flag_zer", {31'd0, flag_zer}, {31'd0, (w == 16'd0) || force_zer});
        chk("flag_neg", {31'd0, flag_neg}, {31'd0, w[15]});
        rd_addr = dst;
        #1;
        chk("rd_dst", {16'd0, rd_data}, {16'd0, mreg[dst]});
        if (mode != 0) begin
            rd_addr = la;
            #1;
            chk("rd_ld", {16'd0, rd_data}, {16'd0, mreg[la]});
        end
        @(negedge clk);
        chk("done_pulse_width", {31'd0, done}, 32'd0);
    endtask

    initial begin
        int acc, ndone, seen_done;
        int acc_cyc [3];
        logic [15:0] v;

        rst = 1'b1; force_zer = 1'b0;
        cmd_valid = 1'b0; cmd_inc = 1'b0; cmd_opc = 3'd0;
        cmd_srca = 2'd0; cmd_srcb = 2'd0; cmd_dst = 2'd0;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 16'd0; rd_addr = 2'd0;
        s_cmd_valid = 1'b0; s_cmd_inc = 1'b0; s_cmd_opc = 3'd0;
        s_cmd_srca = 2'd0; s_cmd_srcb = 2'd0; s_cmd_dst = 2'd0;
        s_ld_en = 1'b0; s_ld_addr = 2'd0; s_ld_data = 16'd0; s_rd_addr = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_res", {16'd0, res}, 32'd0);
        chk("rst_flag_zer", {31'd0, flag_zer}, 32'd0);
        chk("rst_flag_neg", {31'd0, flag_neg}, 32'd0);
        chk("rst_alu_in", {alu_inA, alu_inB}, 32'd0);
        chk("rst_alu_ctl", {28'd0, alu_opc, alu_inc}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            chk("rst_reg", {16'd0, rd_data}, 32'd0);
        end
`ifdef ALU_FLAG_CHECK_EN
        chk("rst_flag_err", {31'd0, flag_err}, 32'd0);
`endif

        load(2'd0, 16'h0003);
        load(2'd1, 16'h0004);
        op(2'd0, 2'd1, 2'd2, 1'b1, 3'd0, 0, 2'd0, 16'd0);
        chk("basic_res", {16'd0, res}, 32'h0008);

        load(2'd0, 16'hFFFF);
        load(2'd1, 16'h0001);
        op(2'd0, 2'd1, 2'd3, 1'b0, 3'd1, 0, 2'd0, 16'd0);
        chk("wrap_zero", {31'd0, flag_zer}, 32'd1);

        load(2'd0, 16'h8000);
        load(2'd1, 16'h0000);
        op(2'd0, 2'd1, 2'd3, 1'b0, 3'd2, 0, 2'd0, 16'd0);
        chk("neg_flag", {30'd0, flag_neg, flag_zer}, 32'd2);

        op(2'd0, 2'd1, 2'd2, 1'b0, 3'd3, 1, 2'd0, 16'h1234);
        chk("issue_load_old_operand", {16'd0, res}, 32'h8000);
        op(2'd0, 2'd1, 2'd2, 1'b0, 3'd4, 2, 2'd2, 16'hABCD);
        chk("capture_wb_wins", {16'd0, res}, 32'h1234);

        // held cmd_valid on the SETTLE=3 instance, self-referencing r0 = r0 + r0 + 1
        s_cmd_valid = 1'b1; s_cmd_inc = 1'b1; s_cmd_opc = 3'd5;
        acc = 0; ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (s_cmd_valid && s_cmd_ready && acc < 3) begin
                acc_cyc[acc] = c;
                acc++;
            end
            if (s_done) ndone++;
            @(negedge clk);
            if (acc == 3) s_cmd_valid = 1'b0;
        end
        v = 16'd0;
        repeat (3) v = v + v + 16'd1;
        chk("held_accepts", acc, 3);
        if (acc == 3) begin
            chk("held_spacing_1", acc_cyc[1] - acc_cyc[0], S3 + 2);
            chk("held_spacing_2", acc_cyc[2] - acc_cyc[1], S3 + 2);
        end
        chk("held_done_count", ndone, 3);
        chk("held_res", {16'd0, s_res}, {16'd0, v});
        s_rd_addr = 2'd0;
        #1;
        chk("held_self_ref_reg", {16'd0, s_rd_data}, {16'd0, v});

        load(2'd0, 16'h0011);
        load(2'd1, 16'h0022);
        cmd_valid = 1'b1; cmd_srca = 2'd0; cmd_srcb = 2'd1; cmd_dst = 2'd2; cmd_inc = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("mid_rst_busy", {31'd0, cmd_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("mid_rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("mid_rst_res", {16'd0, res}, 32'd0);
        chk("mid_rst_alu_inA", {16'd0, alu_inA}, 32'd0);
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            if (done) seen_done++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", seen_done, 0);
        rd_addr = 2'd2;
        #1;
        chk("mid_rst_dst_reg", {16'd0, rd_data}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) load(2'($urandom_range(0, 3)), 16'($urandom));
            op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               int'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 16'($urandom));
        end

`ifdef ALU_FLAG_CHECK_EN
        chk("flag_err_clean", {31'd0, flag_err}, 32'd0);
        load(2'd0, 16'h0002);
        load(2'd1, 16'h0003);
        force_zer = 1'b1;
        op(2'd0, 2'd1, 2'd2, 1'b0, 3'd0, 0, 2'd0, 16'd0);
        force_zer = 1'b0;
        chk("flag_err_set", {31'd0, flag_err}, 32'd1);
        op(2'd0, 2'd1, 2'd3, 1'b0, 3'd0, 0, 2'd0, 16'd0);
        chk("flag_err_sticky", {31'd0, flag_err}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("flag_err_rst", {31'd0, flag_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
Name: alu_driver

Overview:
- Initiator side of the ALU operand/opcode interface: holds a small operand register file and accepts commands over a valid/ready handshake.
- For each command it drives `inA/inB/inc/opc` into a combinational ALU, waits a settle interval, then captures `w/zer/neg`.
- The captured result is written back to a destination register, with flags and a one-cycle done pulse.
- Sits between the sequencing/control logic and the ALU, so the ALU can be exercised by command streams rather than free-running stimulus.

Parameters:
- `WIDTH`, 16, datapath width of operands and result.
- `NREG`, 4, number of operand registers; must be a power of 2, minimum 2.
- `SETTLE`, 1, cycles the ALU inputs are held before capture; minimum 1.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: driver can accept a command.
- `cmd_opc` in 3: ALU opcode for the command.
- `cmd_inc` in 1: ALU carry/increment input for the command.
- `cmd_srca` in log2(NREG): register feeding inA.
- `cmd_srcb` in log2(NREG): register feeding inB.
- `cmd_dst` in log2(NREG): destination register for the result.
- `ld_en` in 1: direct register load strobe.
- `ld_addr` in log2(NREG): register to load.
- `ld_data` in WIDTH: load value.
- `alu_inA` out WIDTH: operand A to the ALU.
- `alu_inB` out WIDTH: operand B to the ALU.
- `alu_inc` out 1: inc to the ALU.
- `alu_opc` out 3: opc to the ALU.
- `alu_w` in WIDTH: ALU result.
- `alu_zer` in 1: ALU zero flag.
- `alu_neg` in 1: ALU negative flag.
- `done` out 1: one-cycle pulse when a result is written back.
- `res` out WIDTH: last captured result.
- `flag_zer` out 1: last captured zero flag.
- `flag_neg` out 1: last captured negative flag.
- `rd_addr` in log2(NREG): combinational register read address.
- `rd_data` out WIDTH: contents of register `rd_addr`.

Behaviour:
- Reset values: all registers 0, state IDLE, `cmd_ready`=1, `done`=0, `res`=0, `flag_zer`=0, `flag_neg`=0. All `alu_*` outputs are 0.
- FSM states IDLE, ISSUE, CAPTURE.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid&cmd_ready` at edge t, latch `reg[srca]`, `reg[srcb]`, `opc`, `inc`, `dst`, then go to ISSUE.
  - A load at that same edge to `srca`/`srcb` is not seen by the operands: they take the pre-edge value.
- ISSUE:
  - `cmd_ready`=0.
  - `alu_*` outputs are driven from the latched values starting at t+1 and held stable.
  - A counter runs from 0 to SETTLE-1; on its last cycle go to CAPTURE.
- CAPTURE (one cycle):
  - At the edge that ends CAPTURE, `reg[dst]`, `res`, `flag_zer` and `flag_neg` are updated from `alu_w`/`alu_zer`/`alu_neg`.
  - `done`=1 during the following cycle; the FSM returns to IDLE.
- Timing:
  - Accept-to-done latency is SETTLE+2 cycles.
  - The next command can be accepted in the cycle `done` is high.
  - `alu_*` outputs hold their last values while in IDLE.
- Flag handling: `flag_zer`/`flag_neg` hold until the next capture; `res` likewise.
- `rd_data` is a combinational read of the register file.
- Loads via `ld_en` are accepted in any state:
  - Operands are already latched, so a load cannot corrupt an in-flight op.
  - A simultaneous load and writeback to the same address: writeback wins.
- Self-referencing commands are legal: `dst == srca == srcb`.
- A `cmd_valid` held while busy is ignored, not queued; the requester keeps it asserted.
- Reset mid-operation abandons the op, with no writeback and no `done`, and applies all reset values.

Optional Feature:
- Macro: `ALU_FLAG_CHECK_EN`.
- When defined:
  - Adds output port `flag_err` (1 bit, sticky, cleared only by `rst`).
  - At capture, the driver recomputes zero = (`alu_w`==0) and neg = `alu_w[WIDTH-1]`.
  - `flag_err` sets if either differs from `alu_zer`/`alu_neg`.
- When undefined, no port and no check logic exist.

Decomposition:
- Package `alu_driver_pkg`: FSM state enum (IDLE/ISSUE/CAPTURE), `OPC_W`=3, default `WIDTH`=16, the register-address-width function log2(NREG).
- One sub-module, `alu_driver_regfile`: NREG x WIDTH register file.
  - Synchronous write with two ports (load, writeback) and writeback priority.
  - Two latched read paths plus the combinational `rd` port.

Test Plan:
- Bench ALU stub: w=inA+inB+inc, zer=(w==0), neg=w[15].
- Load r0=16'h0003, r1=16'h0004, then command opc=0, inc=1, src 0/1, dst 2 with SETTLE=1 -> `alu_inA`=3 and `alu_inB`=4 from t+1; `done` at t+3; r2=`res`=16'h0008; zer=0, neg=0.
- r0=16'hFFFF, r1=16'h0001, inc=0, dst 3 -> r3=0, `flag_zer`=1, `flag_neg`=0. Then r0=16'h8000, r1=0 -> `flag_neg`=1, `flag_zer`=0.
- During ISSUE, `ld_en` writes r0=16'h1234 while the op sources r0 -> result uses the old r0. Then a load at the CAPTURE edge to `dst` -> writeback value wins.
- `cmd_valid` held continuously for 3 commands, SETTLE=3 -> accepts spaced exactly 5 cycles apart; exactly 3 `done` pulses.
- Assert `rst` in ISSUE -> no `done`, `reg[dst]` unchanged (0), `cmd_ready`=1 next cycle.
- With `ALU_FLAG_CHECK_EN`: stub forces `alu_zer`=1 with w=5 -> `flag_err`=1 and stays 1 across later correct ops until `rst`.
